// File: rtl/estacao_pkg.sv
// Shared definitions for the reservation station: entry state encoding and
// the per-entry control record used by estacao_entrada.
package estacao_pkg;

    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;
    localparam logic [1:0] ST_ISSUED = 2'd3;

    // Enough bits to rank up to eight entries by dispatch order
    localparam int AGE_W = 3;

    typedef struct packed {
        logic [1:0] state;
        logic       vj_valid;
        logic       vk_valid;
    } entry_ctrl_t;

endpackage

// File: rtl/estacao_entrada.sv
// One reservation-station entry: holds op/operands and snoops the CDB.
// Optional dispatch-edge CDB capture is enabled by ESTACAO_CDB_BYPASS_EN.
module estacao_entrada
    import estacao_pkg::*;
#(
    parameter int              DATA_W = 16,
    parameter int              TAG_W  = 3,
    parameter int              OP_W   = 3,
    parameter logic [TAG_W-1:0] MY_TAG = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alloc,
    input  logic              grant,
    input  logic [OP_W-1:0]   disp_op,
    input  logic [2:0]        disp_dest,
    input  logic              disp_qj_dep,
    input  logic              disp_qk_dep,
    input  logic [TAG_W-1:0]  disp_qj,
    input  logic [TAG_W-1:0]  disp_qk,
    input  logic [DATA_W-1:0] disp_vj,
    input  logic [DATA_W-1:0] disp_vk,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic [1:0]        state,
    output logic [OP_W-1:0]   op,
    output logic [2:0]        dest,
    output logic [DATA_W-1:0] vj,
    output logic [DATA_W-1:0] vk,
    output logic              freeing
);

    entry_ctrl_t      ent;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic             hit_j;
    logic             hit_k;
    logic             byp_j;
    logic             byp_k;
    logic             load_j;
    logic             load_k;

    assign state = ent.state;

    always_comb begin
        freeing = cdb_valid && (ent.state == ST_ISSUED) && (cdb_tag == MY_TAG);
        hit_j   = cdb_valid && !ent.vj_valid && (qj == cdb_tag);
        hit_k   = cdb_valid && !ent.vk_valid && (qk == cdb_tag);
`ifdef ESTACAO_CDB_BYPASS_EN
        byp_j   = disp_qj_dep && cdb_valid && (disp_qj == cdb_tag);
        byp_k   = disp_qk_dep && cdb_valid && (disp_qk == cdb_tag);
`else
        // The register file forwards a same-edge broadcast in this build
        byp_j   = 1'b0;
        byp_k   = 1'b0;
`endif
        load_j  = !disp_qj_dep || byp_j;
        load_k  = !disp_qk_dep || byp_k;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent  <= '0;
            op   <= '0;
            dest <= '0;
            vj   <= '0;
            vk   <= '0;
            qj   <= '0;
            qk   <= '0;
        end else if (alloc) begin
            op           <= disp_op;
            dest         <= disp_dest;
            qj           <= disp_qj;
            qk           <= disp_qk;
            vj           <= byp_j ? cdb_data : disp_vj;
            vk           <= byp_k ? cdb_data : disp_vk;
            ent.vj_valid <= load_j;
            ent.vk_valid <= load_k;
            ent.state    <= (load_j && load_k) ? ST_READY : ST_WAIT;
        end else begin
            case (ent.state)
                ST_WAIT: begin
                    if (hit_j) begin
                        vj           <= cdb_data;
                        ent.vj_valid <= 1'b1;
                    end
                    if (hit_k) begin
                        vk           <= cdb_data;
                        ent.vk_valid <= 1'b1;
                    end
                    if ((ent.vj_valid || hit_j) && (ent.vk_valid || hit_k))
                        ent.state <= ST_READY;
                end
                ST_READY: begin
                    if (grant)
                        ent.state <= ST_ISSUED;
                end
                ST_ISSUED: begin
                    if (freeing) begin
                        ent.state    <= ST_FREE;
                        ent.vj_valid <= 1'b0;
                        ent.vk_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/estacao_reserva_param.sv
// Parameterised reservation station: allocation, oldest-ready issue and age
// ranking. CDB capture on the dispatch edge is enabled by ESTACAO_CDB_BYPASS_EN.
module estacao_reserva_param
    import estacao_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int DATA_W   = 16,
    parameter int TAG_W    = 3,
    parameter int OP_W     = 3,
    parameter int TAG_BASE = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              disp_valid,
    output logic              disp_ready,
    output logic [TAG_W-1:0]  disp_tag,
    input  logic [OP_W-1:0]   disp_op,
    input  logic [2:0]        disp_dest,
    input  logic              disp_qj_dep,
    input  logic              disp_qk_dep,
    input  logic [TAG_W-1:0]  disp_qj,
    input  logic [TAG_W-1:0]  disp_qk,
    input  logic [DATA_W-1:0] disp_vj,
    input  logic [DATA_W-1:0] disp_vk,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [OP_W-1:0]   issue_op,
    output logic [DATA_W-1:0] issue_vj,
    output logic [DATA_W-1:0] issue_vk,
    output logic [TAG_W-1:0]  issue_tag,
    output logic [2:0]        issue_dest,
    output logic [3:0]        busy_count
);

    localparam int IDX_W = 3;

    logic [1:0]        ent_state [DEPTH];
    logic [OP_W-1:0]   ent_op    [DEPTH];
    logic [2:0]        ent_dest  [DEPTH];
    logic [DATA_W-1:0] ent_vj    [DEPTH];
    logic [DATA_W-1:0] ent_vk    [DEPTH];
    logic [AGE_W-1:0]  age       [DEPTH];
    logic [DEPTH-1:0]  freeing;
    logic [DEPTH-1:0]  alloc;
    logic [DEPTH-1:0]  grant;
    logic [IDX_W-1:0]  alloc_idx;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  hold_idx;
    logic              hold_valid;
    logic              sel_found;
    logic [AGE_W-1:0]  best_age;
    logic [AGE_W-1:0]  freed_age;
    logic [AGE_W-1:0]  new_rank;
    logic              any_free;
    logic [3:0]        busy_cnt;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        estacao_entrada #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W),
            .OP_W   (OP_W),
            .MY_TAG (TAG_W'(TAG_BASE + g))
        ) u_entrada (
            .clock       (clock),
            .reset       (reset),
            .alloc       (alloc[g]),
            .grant       (grant[g]),
            .disp_op     (disp_op),
            .disp_dest   (disp_dest),
            .disp_qj_dep (disp_qj_dep),
            .disp_qk_dep (disp_qk_dep),
            .disp_qj     (disp_qj),
            .disp_qk     (disp_qk),
            .disp_vj     (disp_vj),
            .disp_vk     (disp_vk),
            .cdb_valid   (cdb_valid),
            .cdb_tag     (cdb_tag),
            .cdb_data    (cdb_data),
            .state       (ent_state[g]),
            .op          (ent_op[g]),
            .dest        (ent_dest[g]),
            .vj          (ent_vj[g]),
            .vk          (ent_vk[g]),
            .freeing     (freeing[g])
        );
    end

    always_comb begin
        disp_ready = 1'b0;
        alloc_idx  = '0;
        busy_cnt   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_state[i] == ST_FREE) begin
                disp_ready = 1'b1;
                alloc_idx  = IDX_W'(i);
            end else begin
                busy_cnt = busy_cnt + 4'd1;
            end
        end
        disp_tag   = TAG_W'(TAG_BASE) + TAG_W'(alloc_idx);
        busy_count = busy_cnt;
    end

    // A presented-but-stalled entry stays selected even if an older one wakes
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_state[i] == ST_READY && (!sel_found || age[i] < best_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                best_age  = age[i];
            end
        end
        if (hold_valid)
            sel_idx = hold_idx;
    end

    always_comb begin
        issue_valid = sel_found;
        issue_op    = '0;
        issue_vj    = '0;
        issue_vk    = '0;
        issue_dest  = '0;
        issue_tag   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            alloc[i] = disp_valid && disp_ready && (alloc_idx == IDX_W'(i));
            grant[i] = sel_found && issue_ready && (sel_idx == IDX_W'(i));
            if (sel_found && sel_idx == IDX_W'(i)) begin
                issue_op   = ent_op[i];
                issue_vj   = ent_vj[i];
                issue_vk   = ent_vk[i];
                issue_dest = ent_dest[i];
                issue_tag  = TAG_W'(TAG_BASE) + TAG_W'(sel_idx);
            end
        end
    end

    always_comb begin
        any_free  = |freeing;
        freed_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (freeing[i])
                freed_age = age[i];
        end
        new_rank = AGE_W'(busy_cnt) - AGE_W'(any_free);
    end

    // Ranks stay dense: younger entries close the gap left by a freed one
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                age[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc[i])
                    age[i] <= new_rank;
                else if (freeing[i])
                    age[i] <= '0;
                else if (any_free && ent_state[i] != ST_FREE && age[i] > freed_age)
                    age[i] <= age[i] - AGE_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_idx   <= '0;
        end else begin
            hold_valid <= sel_found && !issue_ready;
            hold_idx   <= sel_idx;
        end
    end

endmodule
